// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and helpers for the neuron parameter loader.
//   state_t      - loader FSM states
//   DEF_BYTE_W   - default width of the parallel parameter input
//   bytes_needed - ceil(chain_bits / byte_w), bytes consumed per load
package bnn_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, CHECK, FINISH} state_t;
   localparam int DEF_BYTE_W = 8;
   function automatic int bytes_needed(input int chain_bits, input int byte_w);
      return (chain_bits + byte_w - 1) / byte_w;
   endfunction
endpackage

// File: rtl/param_loader_if.sv
// param_loader_if: byte valid/ready handshake into the parameter loader.
//   byte_in    - parameter byte, MSB shifted first
//   byte_valid - byte_in is valid (source side)
//   byte_ready - loader takes byte_in this cycle (loader side)
//   master: byte source; slave: the loader
interface param_loader_if #(parameter int BYTE_W = bnn_pkg::DEF_BYTE_W) ();
   logic [BYTE_W-1:0] byte_in;
   logic              byte_valid;
   logic              byte_ready;
   modport master (output byte_in, byte_valid, input byte_ready);
   modport slave (input byte_in, byte_valid, output byte_ready);
endinterface

// File: rtl/param_piso.sv
// param_piso: W-bit parallel-in/serial-out register, MSB first.
//   clk, rst_n - clock, synchronous active-low reset
//   load, d    - capture d
//   shift      - shift left, zero fill
//   clr        - clear contents (takes priority over load/shift)
//   msb        - registered serial output, q[W-1]
module param_piso #(parameter int W = 8) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic         msb
);
   logic [W-1:0] q;
   always_ff @(posedge clk)
      if (!rst_n || clr) q <= '0;
      else if (load) q <= d;
      else if (shift) q <= q << 1;
   assign msb = q[W-1];
endmodule

// File: rtl/param_loader.sv
// param_loader: serialises parameter bytes MSB-first onto the neuron chain,
// holding setup high for exactly CHAIN_BITS cycles per load.
//   clk, rst_n - clock, synchronous active-low reset
//   start      - single-cycle load request (ignored unless idle)
//   bus        - byte_in/byte_valid/byte_ready handshake (slave)
//   setup      - chain shift enable
//   param_out  - serial bit into the first neuron
//   busy       - load in progress
//   done       - one-cycle completion pulse
//   loaded     - chain holds a complete parameter set
//   csum_err   - checksum mismatch (constant 0 unless checksum build)
// Optional: define PARAM_LOADER_CHECKSUM_EN to accept a trailing XOR
// checksum byte in a CHECK state before completion.
module param_loader import bnn_pkg::*; #(
   parameter int CHAIN_BITS = 88,
   parameter int BYTE_W     = DEF_BYTE_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   param_loader_if.slave   bus,
   output logic            setup,
   output logic            param_out,
   output logic            busy,
   output logic            done,
   output logic            loaded,
   output logic            csum_err
);
   localparam int CW = $clog2(CHAIN_BITS + 1);
   localparam int IW = BYTE_W > 1 ? $clog2(BYTE_W) : 1;
`ifdef PARAM_LOADER_CHECKSUM_EN
   localparam state_t END_ST = CHECK;
`else
   localparam state_t END_ST = FINISH;
`endif
   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          accept, shifting, chain_end, byte_end, go;
   assign bus.byte_ready = state == WAIT_BYTE || state == CHECK;
   assign accept    = bus.byte_valid && bus.byte_ready;
   assign shifting  = state == SHIFT;
   assign chain_end = shifting && cnt == CW'(CHAIN_BITS - 1);
   assign byte_end  = idx == IW'(BYTE_W - 1);
   assign go        = state == IDLE && start;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = start ? WAIT_BYTE : IDLE;
         WAIT_BYTE: nxt = accept ? SHIFT : WAIT_BYTE;
         SHIFT:     nxt = chain_end ? END_ST : (byte_end ? WAIT_BYTE : SHIFT);
         CHECK:     nxt = accept ? FINISH : CHECK;
         FINISH:    nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with the
   // state they describe: setup is high in exactly the SHIFT cycles.
   always_ff @(posedge clk)
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         setup  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         loaded <= 1'b0;
      end else begin
         state  <= nxt;
         setup  <= nxt == SHIFT;
         busy   <= nxt == WAIT_BYTE || nxt == SHIFT || nxt == CHECK;
         done   <= nxt == FINISH;
         loaded <= go ? 1'b0 : (nxt == FINISH ? 1'b1 : loaded);
         cnt    <= go ? '0 : (shifting ? cnt + CW'(1) : cnt);
         idx    <= go || (shifting && byte_end) ? '0 : (shifting ? idx + IW'(1) : idx);
      end
   // Cleared on the final chain bit so a partially shifted byte never
   // leaks its discarded bits onto param_out.
   param_piso #(.W(BYTE_W)) u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept && state == WAIT_BYTE),
      .shift (shifting),
      .clr   (chain_end),
      .d     (bus.byte_in),
      .msb   (param_out)
   );
`ifdef PARAM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] xsum;
   always_ff @(posedge clk)
      if (!rst_n || go) begin
         xsum     <= '0;
         csum_err <= 1'b0;
      end else if (accept && state == WAIT_BYTE) xsum <= xsum ^ bus.byte_in;
      else if (accept && state == CHECK) csum_err <= bus.byte_in != xsum;
`else
   assign csum_err = 1'b0;
`endif
endmodule

// File: tb/tb_param_loader.sv
// tb_param_loader: table-driven bench for param_loader with three instances
// (CHAIN_BITS 88, 44, 16). Checksum expectations follow
// PARAM_LOADER_CHECKSUM_EN when the bench is built with it.
module tb_param_loader;
   import bnn_pkg::*;
`ifdef PARAM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   typedef struct {
      int              d;
      int              n;
      logic [11:0][7:0] data;
      int              gap_at;
      int              gap_len;
      bit              csum;
      logic [7:0]      csb;
      bit              spam;
      int              e_setup;
      int              e_acc;
      int              e_ld;
      int              e_tail;
      int              e_err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_v[3];
   logic [7:0] bin[3];
   logic       bval[3];
   logic       brdy[3], setup_v[3], pout_v[3], busy_v[3], done_v[3], loaded_v[3], cerr_v[3];
   int         checks = 0;
   int         errors = 0;
   vec_t       vt[6];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : u
      param_loader_if #(.BYTE_W(8)) bus ();
      assign bus.byte_in    = bin[g];
      assign bus.byte_valid = bval[g];
      assign brdy[g]        = bus.byte_ready;
      param_loader #(.CHAIN_BITS(g == 0 ? 88 : (g == 1 ? 44 : 16)), .BYTE_W(8)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start_v[g]),
         .bus       (bus),
         .setup     (setup_v[g]),
         .param_out (pout_v[g]),
         .busy      (busy_v[g]),
         .done      (done_v[g]),
         .loaded    (loaded_v[g]),
         .csum_err  (cerr_v[g])
      );
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic int outs(input int i);
      return {25'd0, setup_v[i], pout_v[i], busy_v[i], done_v[i], loaded_v[i], cerr_v[i], brdy[i]};
   endfunction

   function automatic vec_t mk(input int d, input int n, input int gap_at, input int gap_len,
                               input bit csum, input logic [7:0] csb, input bit spam, input int e_setup,
                               input int e_acc, input int e_ld, input int e_tail, input int e_err);
      vec_t v;
      v.d = d; v.n = n; v.data = '0; v.gap_at = gap_at; v.gap_len = gap_len; v.csum = csum;
      v.csb = csb; v.spam = spam; v.e_setup = e_setup; v.e_acc = e_acc; v.e_ld = e_ld;
      v.e_tail = e_tail; v.e_err = e_err;
      return v;
   endfunction

   // Runs one load from a negedge; cycle 1 is the first cycle after start is taken.
   task automatic run(input string tag, input vec_t v);
      int   d, cyc, bi, gapc, setups, dones, ld_cyc, done_cyc, extra, gap_bad, mism, total, tail;
      logic q[$];
      logic e[$];
      d = v.d; bi = 0; gapc = 0; setups = 0; dones = 0; ld_cyc = -1; done_cyc = -1;
      extra = 0; gap_bad = 0; mism = 0; tail = 0;
      total = v.n + ((v.csum && CSUM) ? 1 : 0);
      for (int k = 0; k < v.n; k++)
         for (int b = 7; b >= 0; b--)
            if (e.size() < v.e_setup) e.push_back(v.data[k][b]);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      cyc = 1;
      while (cyc < 400 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
         if (setup_v[d]) begin
            setups++;
            q.push_back(pout_v[d]);
         end
         if (done_v[d]) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
            if (v.spam) start_v[d] = 1'b1;
         end
         if (loaded_v[d] && ld_cyc < 0) ld_cyc = cyc;
         if (v.spam && cyc == 20) start_v[d] = 1'b1;
         if (bi == v.gap_at && gapc < v.gap_len && brdy[d]) begin
            bval[d] = 1'b0;
            gapc++;
            if (setup_v[d]) gap_bad++;
         end else if (bi < total) begin
            bval[d] = 1'b1;
            bin[d]  = bi < v.n ? v.data[bi] : v.csb;
         end else bval[d] = 1'b0;
         if (bval[d] && brdy[d]) bi++;
         else if (brdy[d] && bi >= total) extra++;
         @(negedge clk);
         cyc++;
         start_v[d] = 1'b0;
      end
      bval[d] = 1'b0;
      for (int k = 0; k < e.size(); k++)
         if (k >= q.size() || q[k] !== e[k]) mism++;
      if (q.size() >= 4) tail = {q[q.size()-4], q[q.size()-3], q[q.size()-2], q[q.size()-1]};
      chk({tag, " setup_cycles"}, setups, v.e_setup);
      chk({tag, " bytes_accepted"}, bi, v.e_acc);
      chk({tag, " done_pulses"}, dones, 1);
      chk({tag, " done_cycle"}, done_cyc, v.e_ld);
      chk({tag, " loaded_cycle"}, ld_cyc, v.e_ld);
      chk({tag, " stream_mismatches"}, mism, 0);
      chk({tag, " last4_bits"}, tail, v.e_tail);
      chk({tag, " extra_ready"}, extra, 0);
      chk({tag, " gap_setup"}, gap_bad, 0);
      chk({tag, " loaded_end"}, int'(loaded_v[d]), 1);
      chk({tag, " busy_end"}, int'(busy_v[d]), 0);
      chk({tag, " csum_err"}, int'(cerr_v[d]), v.e_err);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         bin[i]     = 8'h00;
         bval[i]    = 1'b0;
      end
      vt[0] = mk(0, 11, -1, 0, 1'b0, 8'h00, 1'b0, 88, 11, 100, 4'b1111, 0);
      for (int k = 0; k < 11; k++) vt[0].data[k] = 8'hA5 + 8'(k);
      vt[1] = mk(1, 6, -1, 0, 1'b0, 8'h00, 1'b0, 44, 6, 51, 4'b0011, 0);
      for (int k = 0; k < 5; k++) vt[1].data[k] = 8'hFF;
      vt[1].data[5] = 8'h3C;
      vt[2] = vt[0];
      vt[2].gap_at = 3;
      vt[2].gap_len = 5;
      vt[2].e_ld = 105;
      vt[3] = vt[0];
      vt[3].spam = 1'b1;
      vt[4] = mk(2, 2, -1, 0, 1'b1, 8'h26, 1'b0, 16, 2 + int'(CSUM), 19 + int'(CSUM), 4'b0100, 0);
      vt[4].data[0] = 8'h12;
      vt[4].data[1] = 8'h34;
      vt[5] = vt[4];
      vt[5].csb = 8'h27;
      vt[5].e_err = int'(CSUM);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("reset_outputs_dut%0d", i), outs(i), 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) run($sformatf("v%0d", i), vt[i]);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      bval[0] = 1'b1;
      bin[0]  = 8'h5A;
      repeat (12) @(negedge clk);
      chk("midload_setup", int'(setup_v[0]), 1);
      chk("midload_loaded", int'(loaded_v[0]), 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_outputs", outs(0), 0);
      rst_n = 1'b1;
      bval[0] = 1'b0;
      @(negedge clk);
      chk("abort_idle", outs(0), 0);
      run("reload", vt[0]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
